// File: rtl/mbank_pkg.sv
// Shared types and elaboration helpers for the memory-bank storage array.
// Latency: n/a. Backpressure: n/a.
package mbank_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        COLL_A_WINS,
        COLL_READ_FIRST
    } coll_policy_e;

    function automatic int byte_lanes(input int data_w);
        return data_w / BYTE_W;
    endfunction

    function automatic bit data_w_ok(input int data_w);
        return (data_w > 0) && ((data_w % BYTE_W) == 0);
    endfunction

endpackage

// File: rtl/dual_port_ram_bank_if.sv
// Port bundle for the dual-port RAM bank: two access ports plus collision status.
// Latency: n/a. Backpressure: none, both ports accept an access every cycle.
interface dual_port_ram_bank_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 16
) ();
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int BE_W   = DATA_W / 8;

    logic              a_en;
    logic              a_we;
    logic [BE_W-1:0]   a_be;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_din;
    logic [DATA_W-1:0] a_dout;
    logic              a_rvalid;

    logic              b_en;
    logic              b_we;
    logic [BE_W-1:0]   b_be;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_din;
    logic [DATA_W-1:0] b_dout;
    logic              b_rvalid;

    logic              coll_pulse;
    logic [CNT_W-1:0]  coll_count;

    modport master (
        output a_en, a_we, a_be, a_addr, a_din,
        input  a_dout, a_rvalid,
        output b_en, b_we, b_be, b_addr, b_din,
        input  b_dout, b_rvalid,
        input  coll_pulse, coll_count
    );

    modport slave (
        input  a_en, a_we, a_be, a_addr, a_din,
        output a_dout, a_rvalid,
        input  b_en, b_we, b_be, b_addr, b_din,
        output b_dout, b_rvalid,
        output coll_pulse, coll_count
    );
endinterface

// File: rtl/ram_rd_pipe.sv
// Read-data output pipeline for one RAM port.
// Latency: LAT cycles from in_vld to out_vld.
// Backpressure: none; out_dat holds the last delivered word between reads.
module ram_rd_pipe #(
    parameter int DATA_W = 32,
    parameter int LAT    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_vld,
    input  logic [DATA_W-1:0] in_dat,
    output logic              out_vld,
    output logic [DATA_W-1:0] out_dat
);
    logic [LAT-1:0]    vld_q;
    logic [DATA_W-1:0] dat_q [LAT];

    // Data stages only load behind a valid so the output word is held between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < LAT; i++) dat_q[i] <= '0;
        end else begin
            vld_q[0] <= in_vld;
            if (in_vld) dat_q[0] <= in_dat;
            for (int i = 1; i < LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign out_vld = vld_q[LAT-1];
    assign out_dat = dat_q[LAT-1];
endmodule

// File: rtl/dual_port_ram_bank.sv
// True dual-port RAM bank with byte enables, A-wins / read-first collision handling.
// Latency: READ_LATENCY+1 edges from read sample to rvalid; collision pulse 2 edges.
// Backpressure: none; every port accepts one access per cycle.
module dual_port_ram_bank
    import mbank_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = $clog2(DEPTH),
    parameter int READ_LATENCY = 1,
    parameter int CNT_W        = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    dual_port_ram_bank_if.slave bus
);
    localparam int           BE_W      = byte_lanes(DATA_W);
    localparam coll_policy_e WW_POLICY = COLL_A_WINS;

    if (!data_w_ok(DATA_W)) begin : g_bad_data_w
        $error("DATA_W must be a positive multiple of 8");
    end

    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return 32'(addr) < 32'(DEPTH);
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    logic              a_hit, b_hit, a_rd, b_rd, same_addr, coll;
    logic [BE_W-1:0]   a_lane_we, b_lane_we;
    logic [DATA_W-1:0] a_rd_word, b_rd_word;

    always_comb begin
        a_hit     = bus.a_en && in_range(bus.a_addr);
        b_hit     = bus.b_en && in_range(bus.b_addr);
        a_rd      = bus.a_en && !bus.a_we;
        b_rd      = bus.b_en && !bus.b_we;
        same_addr = (bus.a_addr == bus.b_addr);
        coll      = a_hit && b_hit && same_addr && (bus.a_we || bus.b_we);
        a_lane_we = (a_hit && bus.a_we) ? bus.a_be : '0;
        b_lane_we = (b_hit && bus.b_we) ? bus.b_be : '0;
        // On a shared address, lanes written by A are masked off B.
        if (WW_POLICY == COLL_A_WINS && same_addr) b_lane_we = b_lane_we & ~a_lane_we;
        a_rd_word = in_range(bus.a_addr) ? mem[bus.a_addr] : '0;
        b_rd_word = in_range(bus.b_addr) ? mem[bus.b_addr] : '0;
    end

    // Array contents are deliberately outside reset so they survive it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < BE_W; i++) begin
            if (a_lane_we[i]) mem[bus.a_addr][i*BYTE_W +: BYTE_W] <= bus.a_din[i*BYTE_W +: BYTE_W];
            if (b_lane_we[i]) mem[bus.b_addr][i*BYTE_W +: BYTE_W] <= bus.b_din[i*BYTE_W +: BYTE_W];
        end
    end

    logic              a_acc_vld, b_acc_vld, coll_q, coll_pulse_q;
    logic [DATA_W-1:0] a_acc_dat, b_acc_dat;
    logic [CNT_W-1:0]  coll_cnt_q;

    // Array read register: captures the pre-write word, giving read-first semantics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_acc_vld    <= 1'b0;
            b_acc_vld    <= 1'b0;
            a_acc_dat    <= '0;
            b_acc_dat    <= '0;
            coll_q       <= 1'b0;
            coll_pulse_q <= 1'b0;
            coll_cnt_q   <= '0;
        end else begin
            a_acc_vld    <= a_rd;
            b_acc_vld    <= b_rd;
            if (a_rd) a_acc_dat <= a_rd_word;
            if (b_rd) b_acc_dat <= b_rd_word;
            coll_q       <= coll;
            coll_pulse_q <= coll_q;
            if (coll_q && (coll_cnt_q != '1)) coll_cnt_q <= coll_cnt_q + 1'b1;
        end
    end

    assign bus.coll_pulse = coll_pulse_q;
    assign bus.coll_count = coll_cnt_q;

    ram_rd_pipe #(.DATA_W(DATA_W), .LAT(READ_LATENCY)) u_a_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (a_acc_vld),
        .in_dat  (a_acc_dat),
        .out_vld (bus.a_rvalid),
        .out_dat (bus.a_dout)
    );

    ram_rd_pipe #(.DATA_W(DATA_W), .LAT(READ_LATENCY)) u_b_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (b_acc_vld),
        .in_dat  (b_acc_dat),
        .out_vld (bus.b_rvalid),
        .out_dat (bus.b_dout)
    );
endmodule

// File: tb/tb_dual_port_ram_bank.sv
// Bench for dual_port_ram_bank: u0 = 16 words, latency 1, 16-bit counter;
// u1 = 12 words, latency 2, 2-bit counter.
module tb_dual_port_ram_bank;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dual_port_ram_bank_if #(.DATA_W(32), .DEPTH(16), .CNT_W(16)) if0 ();
    dual_port_ram_bank_if #(.DATA_W(32), .DEPTH(12), .CNT_W(2))  if1 ();

    dual_port_ram_bank #(.DATA_W(32), .DEPTH(16), .READ_LATENCY(1), .CNT_W(16)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(if0));
    dual_port_ram_bank #(.DATA_W(32), .DEPTH(12), .READ_LATENCY(2), .CNT_W(2)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(if1));

    typedef struct { int due; logic [31:0] dat; } rd_exp_t;
    typedef struct { int due; logic [31:0] cnt; } coll_exp_t;

    rd_exp_t   rq [4][$];
    coll_exp_t cq [2][$];

    function automatic int lat(input int d);
        return (d == 0) ? 1 : 2;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic mon_rd(input int p, input logic v, input logic [31:0] d);
        rd_exp_t it;
        if (rq[p].size() > 0 && rq[p][0].due < cyc) begin
            it = rq[p].pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL rd_missed[%0d]: no rvalid at cycle %0d, expected data %h", p, it.due, it.dat);
        end
        if (v) begin
            if (rq[p].size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rd_unexpected[%0d]: rvalid with data %h at cycle %0d, none expected", p, d, cyc);
            end else begin
                it = rq[p].pop_front();
                chk($sformatf("rd_data[%0d]", p), d, it.dat);
                chk($sformatf("rd_cycle[%0d]", p), 32'(cyc), 32'(it.due));
            end
        end
    endtask

    task automatic mon_coll(input int d, input logic v, input logic [31:0] cnt);
        coll_exp_t it;
        if (cq[d].size() > 0 && cq[d][0].due < cyc) begin
            it = cq[d].pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL coll_missed[%0d]: no coll_pulse at cycle %0d", d, it.due);
        end
        if (v) begin
            if (cq[d].size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL coll_unexpected[%0d]: coll_pulse at cycle %0d, count %0d", d, cyc, cnt);
            end else begin
                it = cq[d].pop_front();
                chk($sformatf("coll_count[%0d]", d), cnt, it.cnt);
                chk($sformatf("coll_cycle[%0d]", d), 32'(cyc), 32'(it.due));
            end
        end
    endtask

    always @(negedge clk) begin
        mon_rd(0, if0.a_rvalid, if0.a_dout);
        mon_rd(1, if0.b_rvalid, if0.b_dout);
        mon_rd(2, if1.a_rvalid, if1.a_dout);
        mon_rd(3, if1.b_rvalid, if1.b_dout);
        mon_coll(0, if0.coll_pulse, 32'(if0.coll_count));
        mon_coll(1, if1.coll_pulse, 32'(if1.coll_count));
    end

    task automatic set_port(input int d, input int p, input logic en, input logic we,
                            input logic [3:0] be, input logic [3:0] addr, input logic [31:0] din);
        if (d == 0 && p == 0) begin
            if0.a_en = en; if0.a_we = we; if0.a_be = be; if0.a_addr = addr; if0.a_din = din;
        end else if (d == 0) begin
            if0.b_en = en; if0.b_we = we; if0.b_be = be; if0.b_addr = addr; if0.b_din = din;
        end else if (p == 0) begin
            if1.a_en = en; if1.a_we = we; if1.a_be = be; if1.a_addr = addr; if1.a_din = din;
        end else begin
            if1.b_en = en; if1.b_we = we; if1.b_be = be; if1.b_addr = addr; if1.b_din = din;
        end
    endtask

    task automatic idle_all();
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) set_port(d, p, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic exp_rd(input int d, input int p, input logic [31:0] dat);
        rq[d*2+p].push_back('{cyc + 1 + lat(d), dat});
    endtask

    task automatic exp_coll(input int d, input logic [31:0] cnt);
        cq[d].push_back('{cyc + 2, cnt});
    endtask

    task automatic wr(input int d, input int p, input logic [3:0] addr,
                      input logic [3:0] be, input logic [31:0] din);
        set_port(d, p, 1'b1, 1'b1, be, addr, din);
        step();
        set_port(d, p, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    endtask

    task automatic rd(input int d, input int p, input logic [3:0] addr, input logic [31:0] dat);
        set_port(d, p, 1'b1, 1'b0, 4'h0, addr, 32'h0);
        exp_rd(d, p, dat);
        step();
        set_port(d, p, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    endtask

    initial begin
        idle_all();
        #1 rst_n = 1'b0;
        #12;
        chk("rst_u0_a_dout", if0.a_dout, 32'h0);
        chk("rst_u0_rvalid", {30'h0, if0.a_rvalid, if0.b_rvalid}, 32'h0);
        chk("rst_u0_coll", {if0.coll_count, 15'h0, if0.coll_pulse}, 32'h0);
        chk("rst_u1_b_dout", if1.b_dout, 32'h0);
        chk("rst_u1_coll", {29'h0, if1.coll_count, if1.coll_pulse}, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(2);

        // Fill and read back every in-range word, then a back-to-back burst on port B.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < ((d == 0) ? 16 : 12); i++) begin
                wr(d, 0, 4'(i), 4'hF, 32'hA5A5_0000 + 32'(i));
                rd(d, 0, 4'(i), 32'hA5A5_0000 + 32'(i));
            end
            for (int i = 0; i < 4; i++) rd(d, 1, 4'(i), 32'hA5A5_0000 + 32'(i));
            step(4);
        end
        chk("u0_b_dout_hold", if0.b_dout, 32'hA5A5_0003);
        chk("u1_b_dout_hold", if1.b_dout, 32'hA5A5_0003);

        // Byte merge and empty byte-enable write.
        wr(0, 0, 4'd3, 4'hF, 32'h1122_3344);
        wr(0, 0, 4'd3, 4'b0101, 32'hFFFF_FFFF);
        rd(0, 0, 4'd3, 32'h11FF_33FF);
        wr(0, 1, 4'd3, 4'h0, 32'h0000_0000);
        rd(0, 1, 4'd3, 32'h11FF_33FF);

        // Write/write collision: A owns its two low bytes, B fills the rest.
        set_port(0, 0, 1'b1, 1'b1, 4'b0011, 4'd5, 32'hAAAA_AAAA);
        set_port(0, 1, 1'b1, 1'b1, 4'b1111, 4'd5, 32'hBBBB_BBBB);
        exp_coll(0, 32'd1);
        step();
        idle_all();
        rd(0, 0, 4'd5, 32'hBBBB_AAAA);

        // Read/write collision is read-first; read/read is not a collision.
        wr(0, 0, 4'd7, 4'hF, 32'h0000_0007);
        set_port(0, 0, 1'b1, 1'b0, 4'h0, 4'd7, 32'h0);
        set_port(0, 1, 1'b1, 1'b1, 4'hF, 4'd7, 32'hDEAD_BEEF);
        exp_rd(0, 0, 32'h0000_0007);
        exp_coll(0, 32'd2);
        step();
        idle_all();
        rd(0, 1, 4'd7, 32'hDEAD_BEEF);
        set_port(0, 0, 1'b1, 1'b0, 4'h0, 4'd7, 32'h0);
        set_port(0, 1, 1'b1, 1'b0, 4'h0, 4'd7, 32'h0);
        exp_rd(0, 0, 32'hDEAD_BEEF);
        exp_rd(0, 1, 32'hDEAD_BEEF);
        step();
        idle_all();
        step(4);
        chk("u0_coll_count_final", 32'(if0.coll_count), 32'd2);

        // Out-of-range accesses on the 12-word bank, then counter saturation.
        wr(1, 0, 4'd13, 4'hF, 32'h0000_1234);
        rd(1, 0, 4'd13, 32'h0);
        rd(1, 1, 4'd1, 32'hA5A5_0001);
        for (int n = 0; n < 5; n++) begin
            set_port(1, 0, 1'b1, 1'b1, 4'hF, 4'd2, 32'h0000_00C0 + 32'(n));
            set_port(1, 1, 1'b1, 1'b1, 4'hF, 4'd2, 32'h0000_00D0 + 32'(n));
            exp_coll(1, (n < 3) ? 32'(n + 1) : 32'd3);
            step();
            idle_all();
            step();
        end
        set_port(1, 0, 1'b1, 1'b1, 4'hF, 4'd14, 32'h1);
        set_port(1, 1, 1'b1, 1'b1, 4'hF, 4'd14, 32'h2);
        step();
        idle_all();
        rd(1, 0, 4'd2, 32'h0000_00C4);
        step(5);
        chk("u1_coll_count_sat", 32'(if1.coll_count), 32'd3);

        // Reset lands between a read edge and its data; nothing may emerge afterwards.
        set_port(0, 0, 1'b1, 1'b0, 4'h0, 4'd0, 32'h0);
        set_port(1, 0, 1'b1, 1'b0, 4'h0, 4'd0, 32'h0);
        step();
        idle_all();
        rst_n = 1'b0;
        #2;
        chk("mid_rst_u0_a_dout", if0.a_dout, 32'h0);
        chk("mid_rst_u0_count", 32'(if0.coll_count), 32'h0);
        chk("mid_rst_u1_a_dout", if1.a_dout, 32'h0);
        chk("mid_rst_u1_count", 32'(if1.coll_count), 32'h0);
        step(2);
        rst_n = 1'b1;
        step(5);
        rd(0, 0, 4'd3, 32'h11FF_33FF);
        rd(1, 0, 4'd2, 32'h0000_00C4);
        rd(1, 1, 4'd11, 32'hA5A5_000B);
        step(6);

        for (int p = 0; p < 4; p++) chk($sformatf("rd_leftover[%0d]", p), 32'(rq[p].size()), 32'd0);
        for (int d = 0; d < 2; d++) chk($sformatf("coll_leftover[%0d]", d), 32'(cq[d].size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
